// File: rtl/riot_bus_pkg.sv
// Shared types and constants for the RRIOT bus initiator.
package riot_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_RESP,
    ST_GAP
  } state_e;

  // Post-response idle counter width (IDLE_GAP up to 15)
  localparam int GAP_W = 4;

  // Timer write: A[1:0] selects the prescaler, A[2] enables the timer irq
  localparam logic [1:0] DIV_1    = 2'b00;
  localparam logic [1:0] DIV_8    = 2'b01;
  localparam logic [1:0] DIV_64   = 2'b10;
  localparam logic [1:0] DIV_1024 = 2'b11;
  localparam int         A_IRQ_EN = 2;

  // Reads: A[0] picks timer value or status register
  localparam logic A_RD_TIMER  = 1'b0;
  localparam logic A_RD_STATUS = 1'b1;

endpackage

// File: rtl/riot_bus_initiator_if.sv
// Command, response, bus and irq signals between host, initiator and responder.
interface riot_bus_initiator_if;
  logic       cmd_valid, cmd_ready, cmd_we;
  logic [2:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_oe;
  logic       bus_enable, bus_we_n;
  logic [2:0] bus_a;
  logic [7:0] bus_do, bus_di;
  logic       bus_oe;
  logic       irq_n, irq_event, irq_clr;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, bus_di, bus_oe,
           irq_n, irq_clr,
    output cmd_ready, rsp_valid, rsp_data, rsp_oe, bus_enable, bus_we_n,
           bus_a, bus_do, irq_event
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, bus_di, bus_oe,
           irq_n, irq_clr,
    input  cmd_ready, rsp_valid, rsp_data, rsp_oe, bus_enable, bus_we_n,
           bus_a, bus_do, irq_event
  );
endinterface

// File: rtl/irq_event_latch.sv
// Falling-edge detector on the active-low irq line with a sticky event flag.
module irq_event_latch (
  input  logic clk,
  input  logic rst,
  input  logic i_irq_n,
  input  logic i_irq_clr,
  output logic o_irq_event
);
  logic r_irq_n_q;
  logic r_event;
  logic w_fall;

  // A held-low level only counts once: edge needs history=1 and current=0
  assign w_fall      = r_irq_n_q & ~i_irq_n;
  assign o_irq_event = r_event;

  // History register plus sticky flag; a new edge beats a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq_n_q <= 1'b1;
      r_event   <= 1'b0;
    end else begin
      r_irq_n_q <= i_irq_n;
      if (w_fall)         r_event <= 1'b1;
      else if (i_irq_clr) r_event <= 1'b0;
    end
  end
endmodule

// File: rtl/riot_bus_initiator.sv
// CPU-side initiator for the RRIOT register bus: one command at a time,
// single-cycle strobe, read data capture and sticky irq edge event.
module riot_bus_initiator
  import riot_bus_pkg::*;
#(
  parameter int IDLE_GAP = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  riot_bus_initiator_if.master bif
);
  localparam logic [GAP_W-1:0] GAP_LOAD = (IDLE_GAP > 0) ? GAP_W'(IDLE_GAP - 1) : '0;

  state_e           r_state, w_next;
  logic             r_we;
  logic [GAP_W-1:0] r_gap;
  logic             r_bus_enable, r_bus_we_n;
  logic [2:0]       r_bus_a;
  logic [7:0]       r_bus_do, r_rsp_data;
  logic             r_rsp_oe;
  logic             w_accept, w_irq_event;

  assign w_accept       = bif.cmd_valid && (r_state == ST_IDLE);
  // Gated by rst so the port reads 0 while reset is held
  assign bif.cmd_ready  = (r_state == ST_IDLE) & ~rst;
  assign bif.rsp_valid  = (r_state == ST_RESP);
  assign bif.rsp_data   = r_rsp_data;
  assign bif.rsp_oe     = r_rsp_oe;
  assign bif.bus_enable = r_bus_enable;
  assign bif.bus_we_n   = r_bus_we_n;
  assign bif.bus_a      = r_bus_a;
  assign bif.bus_do     = r_bus_do;
  assign bif.irq_event  = w_irq_event;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next state: writes skip CAPTURE, reads wait one cycle for registered DO
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:    if (w_accept) w_next = ST_ISSUE;
      ST_ISSUE:   w_next = r_we ? ST_RESP : ST_CAPTURE;
      ST_CAPTURE: w_next = ST_RESP;
      ST_RESP:    if (bif.rsp_ready) w_next = (IDLE_GAP > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:     if (r_gap == '0) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Registered bus drive, response capture and gap counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we         <= 1'b0;
      r_gap        <= '0;
      r_bus_enable <= 1'b0;
      r_bus_we_n   <= 1'b1;
      r_bus_a      <= '0;
      r_bus_do     <= '0;
      r_rsp_data   <= '0;
      r_rsp_oe     <= 1'b0;
    end else begin
      // Strobe is loaded on the accept edge so it is high exactly during ISSUE
      r_bus_enable <= w_accept;
      r_bus_we_n   <= w_accept ? ~bif.cmd_we : 1'b1;
      if (w_accept) begin
        r_we     <= bif.cmd_we;
        r_bus_a  <= bif.cmd_addr;
        r_bus_do <= bif.cmd_wdata;
      end
      if (r_state == ST_ISSUE && r_we) begin
        r_rsp_data <= '0;
        r_rsp_oe   <= 1'b0;
      end
      if (r_state == ST_CAPTURE) begin
        r_rsp_data <= bif.bus_di;
        r_rsp_oe   <= bif.bus_oe;
      end
      if (r_state == ST_RESP && bif.rsp_ready) r_gap <= GAP_LOAD;
      else if (r_state == ST_GAP && r_gap != '0) r_gap <= r_gap - 1'b1;
    end
  end

  irq_event_latch u_irq (
    .clk         (clk),
    .rst         (rst),
    .i_irq_n     (bif.irq_n),
    .i_irq_clr   (bif.irq_clr),
    .o_irq_event (w_irq_event)
  );
endmodule

// File: tb/tb_riot_bus_initiator.sv
// Scoreboard bench: driver pushes expected bus access and response per
// accepted command; a negedge monitor pops and compares.
module tb_riot_bus_initiator;
  localparam int GAP = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  riot_bus_initiator_if bif ();
  riot_bus_initiator #(.IDLE_GAP(GAP)) dut (.clk(clk), .rst(rst), .bif(bif));

  typedef struct { logic we; logic [7:0] data; logic oe; int acc; } rsp_t;
  typedef struct { logic we_n; logic [2:0] a; logic [7:0] d; } bus_t;

  rsp_t       rsp_q[$];
  bus_t       bus_q[$];
  logic [7:0] rd_mem[8];
  logic       rd_oe[8];
  int         checks = 0, errors = 0, cyc = 0, hold = 0;
  bit         rnd_rdy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string p);
    chk({p, "_cmd_ready"}, bif.cmd_ready, 0);
    chk({p, "_rsp_valid"}, bif.rsp_valid, 0);
    chk({p, "_rsp_data"}, bif.rsp_data, 0);
    chk({p, "_rsp_oe"}, bif.rsp_oe, 0);
    chk({p, "_bus_enable"}, bif.bus_enable, 0);
    chk({p, "_bus_we_n"}, bif.bus_we_n, 1);
    chk({p, "_bus_a"}, bif.bus_a, 0);
    chk({p, "_bus_do"}, bif.bus_do, 0);
    chk({p, "_irq_event"}, bif.irq_event, 0);
  endtask

  // Responder: DO/OE valid only in the cycle after a read strobe, junk otherwise
  always @(posedge clk) begin
    if (bif.bus_enable && bif.bus_we_n) begin
      bif.bus_di <= rd_mem[bif.bus_a];
      bif.bus_oe <= rd_oe[bif.bus_a];
    end else begin
      bif.bus_di <= 8'($urandom);
      bif.bus_oe <= 1'($urandom);
    end
  end

  // Response-ready driver: optional hold-off count, else 1 or random
  initial begin
    bif.rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bif.rsp_valid && hold > 0) begin
        bif.rsp_ready = 1'b0;
        hold--;
      end else bif.rsp_ready = rnd_rdy ? 1'($urandom) : 1'b1;
    end
  end

  // Offer one command; expectations are pushed at the accept cycle
  task automatic do_cmd(input logic we, input logic [2:0] a, input logic [7:0] d);
    int t = 0;
    rsp_t r;
    @(negedge clk);
    while (!bif.cmd_ready && t < 200) begin @(negedge clk); t++; end
    if (!bif.cmd_ready) begin chk("accept_timeout", bif.cmd_ready, 1); return; end
    bif.cmd_valid = 1'b1; bif.cmd_we = we; bif.cmd_addr = a; bif.cmd_wdata = d;
    bus_q.push_back('{we_n: ~we, a: a, d: d});
    r.we = we; r.acc = cyc + 1;
    r.data = we ? 8'h00 : rd_mem[a];
    r.oe   = we ? 1'b0 : rd_oe[a];
    rsp_q.push_back(r);
    @(negedge clk);
    // Scramble command fields while busy; the DUT must ignore them
    bif.cmd_valid = 1'b0; bif.cmd_we = 1'($urandom);
    bif.cmd_addr = 3'($urandom); bif.cmd_wdata = 8'($urandom);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((rsp_q.size() != 0 || bus_q.size() != 0) && t < 500) begin @(negedge clk); t++; end
    if (t >= 500) chk("drain_timeout", rsp_q.size(), 0);
  endtask

  // Monitor
  initial begin
    bit prev_en = 0, prev_rv = 0, prev_hs = 0, hs;
    logic [7:0] prev_d = 0;
    logic prev_oe = 0;
    int since = 1000;
    bus_t b;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rst) begin
        rsp_q.delete(); bus_q.delete();
        prev_en = 0; prev_rv = 0; prev_hs = 0; since = 1000;
      end else begin
        if (bif.bus_enable) begin
          chk("strobe_sep", prev_en, 0);
          if (bus_q.size() == 0) chk("bus_unexpected", bif.bus_enable, 0);
          else begin
            b = bus_q.pop_front();
            chk("bus_we_n", bif.bus_we_n, b.we_n);
            chk("bus_a", bif.bus_a, b.a);
            chk("bus_do", bif.bus_do, b.d);
          end
        end else chk("bus_we_n_idle", bif.bus_we_n, 1);

        if (bif.rsp_valid && (!prev_rv || prev_hs)) begin
          if (rsp_q.size() == 0) chk("rsp_unexpected", bif.rsp_valid, 0);
          else begin
            r = rsp_q.pop_front();
            chk("rsp_data", bif.rsp_data, r.data);
            chk("rsp_oe", bif.rsp_oe, r.oe);
            // Edges after the accept edge: write 1, read 2
            chk("rsp_latency", cyc - r.acc, r.we ? 1 : 2);
          end
        end else if (bif.rsp_valid && prev_rv) begin
          chk("rsp_data_stable", bif.rsp_data, prev_d);
          chk("rsp_oe_stable", bif.rsp_oe, prev_oe);
        end

        if (since < 1000) since++;
        if (since >= 1 && since <= GAP) begin
          chk("gap_cmd_ready", bif.cmd_ready, 0);
          chk("gap_bus_enable", bif.bus_enable, 0);
        end else if (since == GAP + 1) chk("gap_release", bif.cmd_ready, 1);

        hs = bif.rsp_valid && bif.rsp_ready;
        if (hs) since = 0;
        prev_en = bif.bus_enable; prev_rv = bif.rsp_valid; prev_hs = hs;
        prev_d = bif.rsp_data; prev_oe = bif.rsp_oe;
      end
    end
  end

  initial begin
    int t;
    bif.cmd_valid = 0; bif.cmd_we = 0; bif.cmd_addr = 0; bif.cmd_wdata = 0;
    bif.irq_n = 1; bif.irq_clr = 0;
    for (int i = 0; i < 8; i++) begin rd_mem[i] = 8'($urandom); rd_oe[i] = 1'($urandom); end
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;
    #1 chk("cmd_ready_after_rst", bif.cmd_ready, 1);

    // Directed accesses
    do_cmd(1'b1, 3'b101, 8'h10); wait_drain();
    rd_mem[4] = 8'h0F; rd_oe[4] = 1'b1;
    do_cmd(1'b0, 3'b100, 8'h00); wait_drain();
    rd_mem[1] = 8'h80; rd_oe[1] = 1'b0;
    do_cmd(1'b0, 3'b001, 8'h5A); wait_drain();
    hold = 5;
    do_cmd(1'b0, 3'b100, 8'h00); wait_drain();
    do_cmd(1'b1, 3'b010, 8'h33); wait_drain();

    // irq edge / sticky / set-priority
    @(negedge clk); chk("irq_idle", bif.irq_event, 0);
    bif.irq_n = 0; bif.irq_clr = 1;
    @(negedge clk); chk("irq_set_wins", bif.irq_event, 1);
    bif.irq_clr = 0;
    @(negedge clk); chk("irq_sticky", bif.irq_event, 1);
    bif.irq_clr = 1;
    @(negedge clk); bif.irq_clr = 0; chk("irq_cleared", bif.irq_event, 0);
    repeat (3) @(negedge clk);
    chk("irq_low_no_reset", bif.irq_event, 0);
    bif.irq_n = 1;
    @(negedge clk); chk("irq_rise_no_set", bif.irq_event, 0);
    bif.irq_n = 0;
    @(negedge clk); chk("irq_second_edge", bif.irq_event, 1);
    bif.irq_n = 1;

    // Reset during CAPTURE of a read drops the command and the irq event
    do_cmd(1'b0, 3'b010, 8'h00);
    t = 0;
    while (!bif.bus_enable && t < 10) begin @(negedge clk); t++; end
    chk("mid_rst_strobe_seen", bif.bus_enable, 1);
    @(negedge clk);
    rst = 1'b1;
    rsp_q.delete(); bus_q.delete();
    #1 check_reset_vals("rst_mid");
    repeat (2) @(negedge clk);
    chk("rst_mid_no_rsp", bif.rsp_valid, 0);
    rst = 1'b0;
    do_cmd(1'b1, 3'b111, 8'hA5); wait_drain();

    // Randomized traffic with random response back-pressure
    rnd_rdy = 1;
    for (int i = 0; i < 40; i++)
      do_cmd(1'($urandom), 3'($urandom), 8'($urandom));
    wait_drain();
    rnd_rdy = 0;
    repeat (GAP + 4) @(negedge clk);
    chk("end_bus_q_empty", bus_q.size(), 0);
    chk("end_rsp_q_empty", rsp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
